wb_sram_slave: RTL and testbench

Wishbone B.4 classic-cycle responder (slave end) backed by an on-chip word-addressed RAM.
- Decodes a configurable byte-address window and enforces a programmable number of wait states.
- Terminates every request with exactly one of ack, err or rty.
- Sits behind the system Wishbone interconnect as the scratch/data memory target for any master built on the shared wb_if bus signals.

---
 rtl/wb_sram_slave_if.sv | 28 ++
 rtl/wb_sram_slave.sv | 133 +++++++++++++
 tb/tb_wb_sram_slave.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_slave_if.sv
// rtl/wb_sram_slave_if.sv - Wishbone classic bus signals shared by master and slave ends
interface wb_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] wb_adr;
    logic [DATA_WIDTH-1:0] wb_wdat;
    logic [3:0]            wb_sel;
    logic                  wb_we;
    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_cti;
    logic                  wb_bte;
    logic [DATA_WIDTH-1:0] wb_rdat;
    logic                  wb_ack;
    logic                  wb_err;
    logic                  wb_rty;

    modport master (
        output wb_adr, wb_wdat, wb_sel, wb_we, wb_cyc, wb_stb, wb_cti, wb_bte,
        input  wb_rdat, wb_ack, wb_err, wb_rty
    );

    modport slave (
        input  wb_adr, wb_wdat, wb_sel, wb_we, wb_cyc, wb_stb, wb_cti, wb_bte,
        output wb_rdat, wb_ack, wb_err, wb_rty
    );
endinterface

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone classic responder backed by a word-addressed on-chip RAM
module wb_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic             mem_busy,
    wb_sram_slave_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_ERR,
        S_RTY
    } state_t;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [IDX_W-1:0]      cap_idx;
    logic [DATA_WIDTH-1:0] cap_wdat;
    logic [3:0]            cap_sel;
    logic                  cap_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  req;
    logic                  in_range;
    logic                  aligned;
    logic                  decode_ok;
    logic [IDX_W-1:0]      live_idx;
    logic                  in_idle;
    logic                  enter_ack;
    logic [IDX_W-1:0]      acc_idx;
    logic [DATA_WIDTH-1:0] acc_wdat;
    logic [3:0]            acc_sel;
    logic                  acc_we;
    logic                  unused_ok;

    assign req = bus.wb_cyc & bus.wb_stb;

    // The window is aligned to its own size, so decode is an upper-bit match and
    // the word index is simply the address bits just above the byte offset.
    assign in_range  = (bus.wb_adr[ADDR_WIDTH-1:IDX_W+2] == BASE_ADDR[ADDR_WIDTH-1:IDX_W+2]);
    assign aligned   = (bus.wb_adr[1:0] == 2'b00);
    assign decode_ok = in_range & aligned;
    assign live_idx  = bus.wb_adr[IDX_W+1:2];

    assign in_idle  = (state == S_IDLE);
    assign acc_idx  = in_idle ? live_idx     : cap_idx;
    assign acc_wdat = in_idle ? bus.wb_wdat  : cap_wdat;
    assign acc_sel  = in_idle ? bus.wb_sel   : cap_sel;
    assign acc_we   = in_idle ? bus.wb_we    : cap_we;

    // With zero wait states the access goes straight from IDLE to ACK using live bus values.
    assign enter_ack = (in_idle && req && decode_ok && !mem_busy && (WAIT_STATES == 0)) ||
                       ((state == S_WAIT) && req && (wait_cnt == 4'd0));

    assign unused_ok = ^{bus.wb_cti, bus.wb_bte};

    always_ff @(posedge wb_clk) begin
        if (enter_ack && acc_we) begin
            for (int n = 0; n < 4; n++) begin
                if (acc_sel[n]) begin
                    mem[acc_idx][8*n +: 8] <= acc_wdat[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            cap_idx     <= '0;
            cap_wdat    <= '0;
            cap_sel     <= 4'd0;
            cap_we      <= 1'b0;
            bus.wb_rdat <= '0;
            bus.wb_ack  <= 1'b0;
            bus.wb_err  <= 1'b0;
            bus.wb_rty  <= 1'b0;
        end else begin
            bus.wb_ack  <= enter_ack;
            bus.wb_err  <= 1'b0;
            bus.wb_rty  <= 1'b0;
            bus.wb_rdat <= '0;
            if (enter_ack && !acc_we) begin
                bus.wb_rdat <= mem[acc_idx];
            end

            case (state)
                S_IDLE: begin
                    if (req) begin
                        cap_idx  <= live_idx;
                        cap_wdat <= bus.wb_wdat;
                        cap_sel  <= bus.wb_sel;
                        cap_we   <= bus.wb_we;
                        if (!decode_ok) begin
                            state      <= S_ERR;
                            bus.wb_err <= 1'b1;
                        end else if (mem_busy) begin
                            state      <= S_RTY;
                            bus.wb_rty <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            state <= S_ACK;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WS_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - randomized self-checking bench for wb_sram_slave against a word-array model
module tb_wb_sram_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy1 = 1'b0;
    logic busy3 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model1 [int];
    logic [31:0] model3 [int];

    always #5 clk = ~clk;

    wb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
    wb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    wb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256),
                    .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut1 (
        .wb_clk(clk), .wb_rst_n(rst_n), .mem_busy(busy1), .bus(bus1.slave));

    wb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256),
                    .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
        .wb_clk(clk), .wb_rst_n(rst_n), .mem_busy(busy3), .bus(bus3.slave));

    task automatic set_bus(input int which, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
        if (which == 1) begin
            bus1.wb_cyc = cyc; bus1.wb_stb = stb; bus1.wb_we = we;
            bus1.wb_adr = adr; bus1.wb_wdat = wdat; bus1.wb_sel = sel;
            bus1.wb_cti = 1'b0; bus1.wb_bte = 1'b0;
        end else begin
            bus3.wb_cyc = cyc; bus3.wb_stb = stb; bus3.wb_we = we;
            bus3.wb_adr = adr; bus3.wb_wdat = wdat; bus3.wb_sel = sel;
            bus3.wb_cti = 1'b0; bus3.wb_bte = 1'b0;
        end
    endtask

    task automatic get_out(input int which, output logic a, output logic e, output logic r,
                           output logic [31:0] d);
        if (which == 1) begin
            a = bus1.wb_ack; e = bus1.wb_err; r = bus1.wb_rty; d = bus1.wb_rdat;
        end else begin
            a = bus3.wb_ack; e = bus3.wb_err; r = bus3.wb_rty; d = bus3.wb_rdat;
        end
    endtask

    // kind: 1 ack, 2 err, 3 rty; lat -1 means no termination within the budget
    task automatic xfer(input int which, input logic we, input logic [31:0] adr,
                        input logic [31:0] wdat, input logic [3:0] sel,
                        output int lat, output int kind, output logic [31:0] rdat,
                        output bit leak, output bit multi);
        logic a, e, r;
        logic [31:0] d;
        lat = -1; kind = 0; rdat = '0; leak = 0; multi = 0;
        @(posedge clk); #1;
        set_bus(which, 1'b1, 1'b1, we, adr, wdat, sel);
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            get_out(which, a, e, r, d);
            if ((int'(a) + int'(e) + int'(r)) > 1) multi = 1;
            if ((!a || we) && d != 32'h0) leak = 1;
            if (a || e || r) begin
                lat  = k;
                kind = a ? 1 : (e ? 2 : 3);
                rdat = d;
            end
        end
        set_bus(which, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] res;
        res = old;
        for (int n = 0; n < 4; n++)
            if (sel[n]) res[8*n +: 8] = nw[8*n +: 8];
        return res;
    endfunction

    task automatic test_reset();
        logic a, e, r;
        logic [31:0] d;
        for (int w = 1; w <= 3; w += 2) begin
            get_out(w, a, e, r, d);
            n_checks++;
            if ({a, e, r} !== 3'b000) begin
                n_fail++; $display("FAIL reset_terms dut%0d: got %b expected 000", w, {a, e, r});
            end
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++; $display("FAIL reset_rdat dut%0d: got %h expected 0", w, d);
            end
        end
    endtask

    task automatic test_basic_rw();
        int lat, kind; logic [31:0] d; bit leak, multi;
        xfer(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, kind, d, leak, multi);
        model1[4] = 32'hDEAD_BEEF;
        n_checks++;
        if (kind !== 1 || lat !== 2) begin
            n_fail++; $display("FAIL basic_write: kind %0d lat %0d expected kind 1 lat 2", kind, lat);
        end
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, lat, kind, d, leak, multi);
        n_checks++;
        if (kind !== 1 || lat !== 2 || d !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL basic_read: kind %0d lat %0d data %h expected 1 2 deadbeef", kind, lat, d);
        end
        n_checks++;
        if (leak || multi) begin
            n_fail++; $display("FAIL basic_rdat_zero: leak %0d multi %0d expected 0 0", leak, multi);
        end
    endtask

    task automatic test_byte_lanes();
        int lat, kind; logic [31:0] d; bit leak, multi;
        xfer(1, 1'b1, 32'h20, 32'h1122_3344, 4'hF, lat, kind, d, leak, multi);
        xfer(1, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, lat, kind, d, leak, multi);
        model1[8] = 32'h11BB_33DD;
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h3, lat, kind, d, leak, multi);
        n_checks++;
        if (kind !== 1 || d !== 32'h11BB_33DD) begin
            n_fail++; $display("FAIL byte_lanes: kind %0d data %h expected 1 11bb33dd", kind, d);
        end
        xfer(1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, lat, kind, d, leak, multi);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, lat, kind, d, leak, multi);
        n_checks++;
        if (kind !== 1 || d !== 32'h11BB_33DD) begin
            n_fail++; $display("FAIL sel_zero_write: kind %0d data %h expected 1 11bb33dd", kind, d);
        end
    endtask

    task automatic test_err();
        int lat, kind; logic [31:0] d; bit leak, multi;
        xfer(1, 1'b0, 32'h400, 32'h0, 4'hF, lat, kind, d, leak, multi);
        n_checks++;
        if (kind !== 2 || lat !== 1 || multi) begin
            n_fail++; $display("FAIL err_range: kind %0d lat %0d expected 2 1", kind, lat);
        end
        xfer(1, 1'b1, 32'h13, 32'h5555_5555, 4'hF, lat, kind, d, leak, multi);
        n_checks++;
        if (kind !== 2 || lat !== 1 || multi) begin
            n_fail++; $display("FAIL err_misalign: kind %0d lat %0d expected 2 1", kind, lat);
        end
        xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, lat, kind, d, leak, multi);
        n_checks++;
        if (d !== model1[4]) begin
            n_fail++; $display("FAIL err_ram_unchanged: got %h expected %h", d, model1[4]);
        end
    endtask

    task automatic test_retry();
        int lat, kind; logic [31:0] d; bit leak, multi;
        xfer(1, 1'b1, 32'h30, 32'h0102_0304, 4'hF, lat, kind, d, leak, multi);
        busy1 = 1'b1;
        xfer(1, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, lat, kind, d, leak, multi);
        busy1 = 1'b0;
        n_checks++;
        if (kind !== 3 || lat !== 1) begin
            n_fail++; $display("FAIL retry_term: kind %0d lat %0d expected 3 1", kind, lat);
        end
        xfer(1, 1'b0, 32'h30, 32'h0, 4'hF, lat, kind, d, leak, multi);
        n_checks++;
        if (d !== 32'h0102_0304) begin
            n_fail++; $display("FAIL retry_ram_unchanged: got %h expected 01020304", d);
        end
        xfer(1, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, lat, kind, d, leak, multi);
        n_checks++;
        if (kind !== 1 || lat !== 2) begin
            n_fail++; $display("FAIL retry_then_ack: kind %0d lat %0d expected 1 2", kind, lat);
        end
        model1[12] = 32'hCAFE_F00D;
    endtask

    task automatic test_abort();
        int lat, kind; logic [31:0] d; bit leak, multi;
        logic a, e, r;
        bit seen;
        xfer(3, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, lat, kind, d, leak, multi);
        n_checks++;
        if (kind !== 1 || lat !== 4) begin
            n_fail++; $display("FAIL ws3_write_latency: kind %0d lat %0d expected 1 4", kind, lat);
        end
        model3[16] = 32'h0BAD_F00D;
        @(posedge clk); #1;
        set_bus(3, 1'b1, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus3.wb_stb = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            get_out(3, a, e, r, d);
            if (a || e || r) seen = 1;
        end
        set_bus(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL abort_no_term: got termination expected none");
        end
        xfer(3, 1'b0, 32'h40, 32'h0, 4'hF, lat, kind, d, leak, multi);
        n_checks++;
        if (d !== model3[16]) begin
            n_fail++; $display("FAIL abort_no_write: got %h expected %h", d, model3[16]);
        end
    endtask

    task automatic test_back_to_back();
        int lat, kind; logic [31:0] d; bit leak, multi;
        logic a, e, r;
        int first, second;
        logic [31:0] d1, d2;
        xfer(3, 1'b1, 32'h44, 32'h1357_9BDF, 4'hF, lat, kind, d, leak, multi);
        xfer(3, 1'b1, 32'h48, 32'h2468_ACE0, 4'hF, lat, kind, d, leak, multi);
        first = -1; second = -1; d1 = '0; d2 = '0;
        @(posedge clk); #1;
        set_bus(3, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
        for (int k = 0; k < 30 && second < 0; k++) begin
            @(negedge clk);
            get_out(3, a, e, r, d);
            if (a && first < 0) begin
                first = k; d1 = d;
                bus3.wb_adr = 32'h48;
            end else if (a) begin
                second = k; d2 = d;
            end
        end
        set_bus(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_checks++;
        if (first !== 4 || second !== 9) begin
            n_fail++; $display("FAIL b2b_spacing: acks at %0d and %0d expected 4 and 9", first, second);
        end
        n_checks++;
        if (d1 !== 32'h1357_9BDF || d2 !== 32'h2468_ACE0) begin
            n_fail++; $display("FAIL b2b_data: got %h %h expected 13579bdf 2468ace0", d1, d2);
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, kind; logic [31:0] d; bit leak, multi;
        logic a, e, r;
        xfer(1, 1'b1, 32'h50, 32'h7777_0000, 4'hF, lat, kind, d, leak, multi);
        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b1, 1'b1, 32'h50, 32'h9999_9999, 4'hF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        get_out(1, a, e, r, d);
        n_checks++;
        if ({a, e, r} !== 3'b000 || d !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_outputs: terms %b rdat %h expected 000 0", {a, e, r}, d);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(1, 1'b0, 32'h50, 32'h0, 4'hF, lat, kind, d, leak, multi);
        n_checks++;
        if (kind !== 1 || lat !== 2 || d !== 32'h7777_0000) begin
            n_fail++; $display("FAIL reset_mid_discard: kind %0d lat %0d data %h expected 1 2 77770000", kind, lat, d);
        end
    endtask

    task automatic test_random();
        int lat, kind, exp_kind, exp_lat, widx;
        logic [31:0] d, adr, wdat, exp_d;
        logic [3:0] sel;
        logic we;
        bit leak, multi, busy;
        int pick;
        for (int i = 0; i < 8; i++) begin
            wdat = $urandom;
            xfer(1, 1'b1, 32'h80 + 32'(i * 4), wdat, 4'hF, lat, kind, d, leak, multi);
            model1[32 + i] = wdat;
        end
        for (int it = 0; it < 60; it++) begin
            pick = $urandom_range(0, 9);
            widx = 32 + $urandom_range(0, 7);
            adr  = 32'(widx * 4);
            if (pick == 0) adr = adr + 32'($urandom_range(1, 3));
            if (pick == 1) adr = 32'h400 + 32'($urandom_range(0, 4095) * 4);
            busy = ($urandom_range(0, 5) == 0);
            we   = 1'($urandom_range(0, 1));
            wdat = $urandom;
            sel  = 4'($urandom_range(0, 15));
            if (adr >= 32'h400 || adr % 4 != 0) exp_kind = 2;
            else if (busy) exp_kind = 3;
            else exp_kind = 1;
            exp_lat = (exp_kind == 1) ? 2 : 1;
            exp_d   = (exp_kind == 1 && !we) ? model1[widx] : 32'h0;
            busy1 = busy;
            xfer(1, we, adr, wdat, sel, lat, kind, d, leak, multi);
            busy1 = 1'b0;
            if (exp_kind == 1 && we) model1[widx] = merge(model1[widx], wdat, sel);
            n_checks++;
            if (kind !== exp_kind || lat !== exp_lat) begin
                n_fail++; $display("FAIL rand_term[%0d]: kind %0d lat %0d expected %0d %0d", it, kind, lat, exp_kind, exp_lat);
            end
            n_checks++;
            if (d !== exp_d || leak || multi) begin
                n_fail++; $display("FAIL rand_data[%0d]: data %h leak %0d multi %0d expected %h 0 0", it, d, leak, multi, exp_d);
            end
        end
        for (int i = 0; i < 8; i++) begin
            xfer(1, 1'b0, 32'h80 + 32'(i * 4), 32'h0, 4'hF, lat, kind, d, leak, multi);
            n_checks++;
            if (d !== model1[32 + i]) begin
                n_fail++; $display("FAIL rand_final[%0d]: got %h expected %h", i, d, model1[32 + i]);
            end
        end
    endtask

    initial begin
        set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_bus(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_rw();
        test_byte_lanes();
        test_err();
        test_retry();
        test_abort();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
